ilog_unit: RTL and testbench

ILOG_UNIT -- requirements
Module: ilog_unit

---
 rtl/ilog_unit.sv | 101 ++++++++++
 tb/tb_ilog_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ilog_unit.sv
// Iterative integer logarithm: floor or ceil of log_base(value) by repeated
// multiplication, one multiply per ITER cycle. Reports exactness and invalid operands.
module ilog_unit #(
  parameter int WIDTH = 16,
  parameter int RW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    result,
  output logic             exact,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   base_q;
  logic [WIDTH-1:0]   value_q;
  logic               mode_q;
  // acc is double width: in ceil mode it can overshoot value by up to a factor of base.
  logic [2*WIDTH-1:0] acc;
  logic [RW-1:0]      k;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] value_ext;
  logic               stop;

  // Multiply only happens while acc < 2^WIDTH, so the low half of acc is exact.
  always_comb begin
    value_ext = {{WIDTH{1'b0}}, value_q};
    prod      = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, base_q};
    stop      = mode_q ? (acc >= value_ext) : (prod > value_ext);
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    busy = (state == ITER);
    done = (state == DONE);
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      value_q <= '0;
      mode_q  <= 1'b0;
      acc     <= {{(2*WIDTH-1){1'b0}}, 1'b1};
      k       <= '0;
      result  <= '0;
      exact   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q  <= base;
            value_q <= value;
            mode_q  <= mode;
            acc     <= {{(2*WIDTH-1){1'b0}}, 1'b1};
            k       <= '0;
            result  <= '0;
            exact   <= 1'b0;
            if (base < WIDTH'(2) || value == '0) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (stop) begin
            result <= k;
            exact  <= (acc == value_ext);
            state  <= DONE;
          end else begin
            acc <= prod;
            k   <= k + RW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ilog_unit.sv
// Self-checking bench for ilog_unit: cycle-level reference model plus directed vectors.
module tb_ilog_unit;

  localparam int WIDTH = 16;
  localparam int RW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] base = '0;
  logic [WIDTH-1:0] value = '0;
  logic             mode = 1'b0;
  logic             busy;
  logic             done;
  logic [RW-1:0]    result;
  logic             exact;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  ilog_unit #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .base   (base),
    .value  (value),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .result (result),
    .exact  (exact),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: floor = largest r with b^r <= v, ceil = smallest r with b^r >= v.
  function automatic int ref_log(input longint b, input longint v, input bit m);
    longint p = 1;
    int r = 0;
    if (m) begin
      while (p < v) begin p = p * b; r++; end
    end else begin
      while (p * b <= v) begin p = p * b; r++; end
    end
    return r;
  endfunction

  function automatic bit ref_exact(input longint b, input longint v, input bit m);
    longint p = 1;
    int r = ref_log(b, v, m);
    for (int i = 0; i < r; i++) p = p * b;
    return (p == v);
  endfunction

  // Reference timeline: outputs cleared on accept, published after result+1 ITER cycles.
  bit     m_busy = 0, m_done = 0, m_exact = 0, m_err = 0;
  int     m_res = 0, m_left = 0, p_res = 0;
  bit     p_exact = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_res <= 0; m_exact <= 0; m_err <= 0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 0;
        m_done  <= 1;
        m_res   <= p_res;
        m_exact <= p_exact;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      m_res <= 0; m_exact <= 0; m_err <= 0;
      if (base < 2 || value == 0) begin
        m_done <= 1;
        m_err  <= 1;
      end else begin
        m_busy  <= 1;
        p_res   <= ref_log(base, value, mode);
        p_exact <= ref_exact(base, value, mode);
        m_left  <= ref_log(base, value, mode) + 1;
      end
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (armed && rst_n) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc result", result, m_res);
      chk("cyc exact", exact, m_exact);
      chk("cyc err", err, m_err);
      if (busy && done) chk("busy&done", 1, 0);
    end
  end

  // Issue one operation (caller is just after a falling edge) and check literal expectations.
  task automatic run_op(input string name, input int b, input int v, input bit m,
                        input int exp_res, input bit exp_ex, input bit exp_err,
                        input int exp_edge, input bit pulse);
    bit seen = 0;
    start = 1'b1;
    base  = b[WIDTH-1:0];
    value = v[WIDTH-1:0];
    mode  = m;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        base  = base ^ 16'hBEEF;
        value = ~value;
        mode  = ~mode;
      end
      if (pulse && n == 3) begin
        start = 1'b1;
        base  = 16'd3;
      end
      if (pulse && n == 4) start = 1'b0;
      if (done) begin
        seen = 1;
        chk({name, " done edge"}, n, exp_edge);
        chk({name, " result"}, result, exp_res);
        chk({name, " exact"}, exact, exp_ex);
        chk({name, " err"}, err, exp_err);
      end
    end
    if (!seen) chk({name, " done timeout"}, 0, 1);
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
    chk("reset exact", exact, 0);
    chk("reset err", err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;
    @(negedge clk);

    run_op("floor 3^?=81",    3,     81, 0,  4, 1, 0,  6, 0);
    run_op("floor 10,999",   10,    999, 0,  2, 0, 0,  4, 0);
    run_op("ceil 10,999",    10,    999, 1,  3, 0, 0,  5, 0);
    // Outputs hold through IDLE.
    repeat (2) @(negedge clk);
    chk("hold result", result, 3);
    chk("hold done", done, 0);
    run_op("floor 2,65535",   2,  65535, 0, 15, 0, 0, 17, 0);
    run_op("ceil 2,65535",    2,  65535, 1, 16, 0, 0, 18, 0);
    run_op("floor 2,1",       2,      1, 0,  0, 1, 0,  2, 0);
    run_op("ceil 2,1",        2,      1, 1,  0, 1, 0,  2, 0);
    run_op("base 1",          1,     77, 0,  0, 0, 1,  1, 0);
    run_op("value 0",         5,      0, 1,  0, 0, 1,  1, 0);
    run_op("base 0",          0,      5, 0,  0, 0, 1,  1, 0);
    run_op("ceil 3,82",       3,     82, 1,  5, 0, 0,  7, 0);
    run_op("ceil 2,1024",     2,   1024, 1, 10, 1, 0, 12, 0);
    run_op("floor 2,1024 pulse", 2, 1024, 0, 10, 1, 0, 12, 1);

    // Abort mid-ITER with an asynchronous reset.
    start = 1'b1; base = 16'd2; value = 16'd1024; mode = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-abort busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort result", result, 0);
    chk("abort exact", exact, 0);
    chk("abort err", err, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort no done", done, 0);
    end
    rst_n = 1'b1;
    run_op("restart 3,81",    3,     81, 0,  4, 1, 0,  6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
